// File: rtl/uart_rx_loader.sv
// UART 8N1 receiver that streams each received byte into a frame buffer BRAM
// and pulses load_done once the last pixel of a frame has been written.
module uart_rx_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_PIXELS   = 4096,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              load_done,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic              rx_p0, rx_p1;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic [ADDR_W-1:0] pix, pix_nxt;
  logic              ferr_nxt;

  // Stage p0 -> p1: metastability synchronizer, idles high like the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      pix       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      pix       <= pix_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    pix_nxt     = pix;
    ferr_nxt    = frame_err;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_p1) state_nxt = START;
      end
      // Mid-bit check of the start bit filters short low glitches
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_p1 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt            = '0;
          shreg_nxt[bit_idx] = rx_p1;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_p1) begin
            state_nxt = WRITE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WRITE: begin
        cnt_nxt = '0;
        if (pix == PIX_LAST) begin
          pix_nxt   = '0;
          state_nxt = DONE;
        end else begin
          pix_nxt   = pix + ADDR_W'(1);
          state_nxt = IDLE;
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en     = (state == WRITE);
  assign load_done = (state == DONE);
  assign busy      = (state != IDLE);
  assign wr_addr   = pix;
  assign wr_data   = shreg;

endmodule

// File: doc/uart_rx_loader.md
UART_RX_LOADER -- requirements
Module: uart_rx_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868; clocks per UART bit period, minimum 4.
REQ-002 Parameter NUM_PIXELS, default 4096; bytes per image frame (64x64 input to pooling).
REQ-003 Parameter ADDR_W, default 16; width of the BRAM write address.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port clk  in  1  system clock; all state updates on its rising edge.
REQ-006 Port rst  in  1  asynchronous active-high reset.
REQ-007 Port rx  in  1  serial line, idle high, 8N1, LSB first; asynchronous to clk.
REQ-008 Port wr_en  out  1  one-cycle BRAM write strobe.
REQ-009 Port wr_addr  out  ADDR_W  BRAM write address, valid while wr_en=1.
REQ-010 Port wr_data  out  8  received byte, valid while wr_en=1.
REQ-011 Port load_done  out  1  one-cycle pulse after the last frame byte is written; drives the pooling start input.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port frame_err  out  1  sticky flag; set on a low stop bit.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP, WRITE, DONE.
REQ-016 IDLE: on synchronized rx=0, clear the bit-period counter and go to START.
REQ-017 START: after CLKS_PER_BIT/2 cycles, resample; if 0, go to DATA; if 1 (glitch), return to IDLE with no write and no error.
REQ-018 DATA: sample every CLKS_PER_BIT cycles; shift the sample into bit index 0..7, LSB first; after bit 7, go to STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, sample; if 1, go to WRITE; if 0, set frame_err, drop the byte, hold pixel count, and go to IDLE.
REQ-020 WRITE: assert wr_en for exactly one cycle, with wr_addr = pixel count and wr_data = received byte.
REQ-021 WRITE exit: if pixel count = NUM_PIXELS-1, clear count to 0 and go to DONE; otherwise increment count and go to IDLE.
REQ-022 DONE: assert load_done for exactly one cycle, then go to IDLE; the next byte starts a new frame at address 0.
REQ-023 Pixel count SHALL be ADDR_W bits and never exceed NUM_PIXELS-1.
REQ-024 A start edge during WRITE or DONE SHALL be detected in the IDLE state that follows; with CLKS_PER_BIT >= 4 this loses no byte.
REQ-025 wr_en and load_done SHALL never be high in the same cycle.
REQ-026 frame_err SHALL clear only on rst.
REQ-027 Latency: wr_en SHALL rise no more than 2 + 9.5*CLKS_PER_BIT + 3 cycles after the rx falling edge of the start bit.

Reset
REQ-028 On rst=1, regardless of clk: state IDLE; pixel count 0; shift register 0; synchronizer 1.
REQ-029 On rst=1, outputs SHALL take wr_en=0, wr_addr=0, wr_data=0, load_done=0, busy=0, frame_err=0.
REQ-030 Reset mid-byte or mid-frame SHALL discard partial data; the next frame starts at address 0.

Verification (CLKS_PER_BIT=16, NUM_PIXELS=16)
REQ-031 Send byte 0xA5 with a valid stop bit -> one wr_en pulse with wr_addr=0 and wr_data=0xA5; busy falls after the write.
REQ-032 Send bytes 0x00..0x0F back to back -> 16 writes at addresses 0..15 carrying matching data; load_done pulses once, one cycle after the write to address 15.
REQ-033 Send a 4-cycle low glitch on rx -> no wr_en pulse, frame_err=0, FSM back in IDLE.
REQ-034 Send byte 0x3C with stop bit 0 -> no write, frame_err=1 and held; the next valid byte 0x11 writes to the same address as the dropped byte.
REQ-035 Assert rst after 7 of 16 bytes, then resend 16 bytes -> writes restart at address 0; exactly one load_done pulse.
REQ-036 After load_done, send one more byte 0x77 -> write at address 0 with data 0x77.
